vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; the next generation of the single-axis horizontal sync block.
- Generates both horizontal and vertical timing from chained counters.
- Sync pulse placement and polarity are configurable; also provides active-video flag, pixel coordinates and line/frame boundary strobes.
- Sits between the pixel-enable divider and the frame-buffer/pixel pipeline; all logic runs on the system clock, gated by the pixel enable.

---
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: chained horizontal/vertical counters advanced by a
// pixel enable, with sync, active-video, coordinate and boundary-strobe decodes.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned H_BITS    = 10,
  parameter int unsigned V_BITS    = 10
) (
  input  logic              clk,
  input  logic              i_sclr,
  input  logic              i_px_clk,
  output logic              o_vga_hsync,
  output logic              o_vga_vsync,
  output logic              o_active,
  output logic [H_BITS-1:0] o_x,
  output logic [V_BITS-1:0] o_y,
  output logic              o_line_end,
  output logic              o_frame_end
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_TOTAL - 1);
  localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_TOTAL - 1);

  logic [H_BITS-1:0] h_cnt;
  logic [V_BITS-1:0] v_cnt;
  logic [31:0]       h_wide;
  logic [31:0]       v_wide;
  logic              h_last;
  logic              v_last;
  logic              h_in_sync;
  logic              v_in_sync;

  // Counter chain; clear wins over the pixel enable.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_px_clk) begin
      if (h_cnt < H_LAST) begin
        h_cnt <= h_cnt + H_BITS'(1);
      end else begin
        h_cnt <= '0;
      end
      if (h_last) begin
        if (v_cnt < V_LAST) begin
          v_cnt <= v_cnt + V_BITS'(1);
        end else begin
          v_cnt <= '0;
        end
      end
    end
  end

  // Range compares run in 32 bits so a region ending exactly at 2^BITS still decodes.
  always_comb begin
    h_wide    = 32'(h_cnt);
    v_wide    = 32'(v_cnt);
    h_last    = (h_cnt == H_LAST);
    v_last    = (v_cnt == V_LAST);
    h_in_sync = (h_wide >= H_SYNC_START) && (h_wide < H_SYNC_END);
    v_in_sync = (v_wide >= V_SYNC_START) && (v_wide < V_SYNC_END);
  end

  always_comb begin
    o_vga_hsync = h_in_sync ? HSYNC_POL : ~HSYNC_POL;
    o_vga_vsync = v_in_sync ? VSYNC_POL : ~VSYNC_POL;
    o_active    = (h_wide < H_ACTIVE) && (v_wide < V_ACTIVE);
    o_x         = h_cnt;
    o_y         = v_cnt;
    o_line_end  = i_px_clk && h_last && !i_sclr;
    o_frame_end = o_line_end && v_last;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, inverted polarity with zero
// front porch, short lines with default vertical timing, and a tiny wrap config.
module tb_vga_timing_gen;

  logic clk;
  logic i_sclr;
  logic i_px_clk;

  int total;
  int bad;

  // default configuration
  logic       d_hs, d_vs, d_act, d_le, d_fe;
  logic [9:0] d_x, d_y;
  // positive polarity, H_FP = 0
  logic       p_hs, p_vs, p_act, p_le, p_fe;
  logic [9:0] p_x, p_y;
  // 8-pixel lines, default vertical timing
  logic       v_hs, v_vs, v_act, v_le, v_fe;
  logic [2:0] v_x;
  logic [9:0] v_y;
  // 8x6 raster in 3-bit counters
  logic       s_hs, s_vs, s_act, s_le, s_fe;
  logic [2:0] s_x, s_y;

  vga_timing_gen dut (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .o_vga_hsync(d_hs), .o_vga_vsync(d_vs), .o_active(d_act),
    .o_x(d_x), .o_y(d_y), .o_line_end(d_le), .o_frame_end(d_fe)
  );

  vga_timing_gen #(.H_FP(0), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)) dut_p (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .o_vga_hsync(p_hs), .o_vga_vsync(p_vs), .o_active(p_act),
    .o_x(p_x), .o_y(p_y), .o_line_end(p_le), .o_frame_end(p_fe)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .H_BITS(3)) dut_v (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .o_vga_hsync(v_hs), .o_vga_vsync(v_vs), .o_active(v_act),
    .o_x(v_x), .o_y(v_y), .o_line_end(v_le), .o_frame_end(v_fe)
  );

  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1), .H_BITS(3),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .V_BITS(3)) dut_s (
    .clk(clk), .i_sclr(i_sclr), .i_px_clk(i_px_clk),
    .o_vga_hsync(s_hs), .o_vga_vsync(s_vs), .o_active(s_act),
    .o_x(s_x), .o_y(s_y), .o_line_end(s_le), .o_frame_end(s_fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n pixel enables, one every 4th clk; returns with the enable low
  task automatic en(input int n);
    repeat (n) begin
      @(negedge clk) i_px_clk = 1'b1;
      @(negedge clk) i_px_clk = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
    #1;
  endtask

  // n back-to-back enables; returns with the enable still high
  task automatic run(input int n);
    i_px_clk = 1'b1;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear();
    @(negedge clk) begin i_sclr = 1'b1; i_px_clk = 1'b0; end
    @(negedge clk) i_sclr = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    i_sclr   = 1'b0;
    i_px_clk = 1'b0;

    // reset and idle hold
    @(negedge clk) i_sclr = 1'b1;
    repeat (2) @(negedge clk);
    i_sclr = 1'b0;
    #1;
    chk("rst_x", 32'(d_x), 0);
    chk("rst_y", 32'(d_y), 0);
    chk("rst_active", 32'(d_act), 1);
    chk("rst_hsync", 32'(d_hs), 1);
    chk("rst_vsync", 32'(d_vs), 1);
    chk("rst_line_end", 32'(d_le), 0);
    chk("rst_frame_end", 32'(d_fe), 0);
    chk("rst_pol_hsync", 32'(p_hs), 0);
    chk("rst_pol_vsync", 32'(p_vs), 0);
    repeat (5) @(negedge clk);
    #1;
    chk("idle_x", 32'(d_x), 0);
    chk("idle_active", 32'(d_act), 1);

    // one full default line at one enable per 4 clks
    en(639);
    chk("x639", 32'(d_x), 639);
    chk("x639_active", 32'(d_act), 1);
    chk("p_x639_hsync", 32'(p_hs), 0);
    en(1);
    chk("x640_active", 32'(d_act), 0);
    chk("x640_hsync", 32'(d_hs), 1);
    chk("p_x640_hsync", 32'(p_hs), 1);
    en(15);
    chk("x655_hsync", 32'(d_hs), 1);
    en(1);
    chk("x656_hsync", 32'(d_hs), 0);
    en(79);
    chk("x735_hsync", 32'(d_hs), 0);
    chk("p_x735_hsync", 32'(p_hs), 1);
    en(1);
    chk("p_x736_hsync", 32'(p_hs), 0);
    en(15);
    chk("x751_hsync", 32'(d_hs), 0);
    en(1);
    chk("x752_hsync", 32'(d_hs), 1);
    en(47);
    chk("x799", 32'(d_x), 799);
    chk("x799_no_enable_line_end", 32'(d_le), 0);
    chk("p_wrap_x", 32'(p_x), 15);
    chk("p_wrap_y", 32'(p_y), 1);
    @(negedge clk) i_px_clk = 1'b1;
    #1;
    chk("line_end_800", 32'(d_le), 1);
    chk("frame_end_800", 32'(d_fe), 0);
    chk("p_line_end_mid", 32'(p_le), 0);
    @(negedge clk) i_px_clk = 1'b0;
    #1;
    chk("after_line_x", 32'(d_x), 0);
    chk("after_line_y", 32'(d_y), 1);
    chk("after_line_strobe", 32'(d_le), 0);

    // clear mid-line on an enable edge, including at the line's last pixel
    en(700);
    chk("mid_x700", 32'(d_x), 700);
    chk("mid_y1", 32'(d_y), 1);
    en(99);
    @(negedge clk) begin i_sclr = 1'b1; i_px_clk = 1'b1; end
    #1;
    chk("sclr_masks_line_end", 32'(d_le), 0);
    chk("sclr_masks_frame_end", 32'(d_fe), 0);
    @(negedge clk) begin i_sclr = 1'b0; i_px_clk = 1'b0; end
    #1;
    chk("sclr_x", 32'(d_x), 0);
    chk("sclr_y", 32'(d_y), 0);
    chk("sclr_hsync", 32'(d_hs), 1);

    // continuous enable: default vertical timing with 8-pixel lines
    clear();
    run(3919);
    chk("v489_y", 32'(v_y), 489);
    chk("v489_vsync", 32'(v_vs), 1);
    chk("v489_line_end", 32'(v_le), 1);
    chk("v489_frame_end", 32'(v_fe), 0);
    chk("s_count3919_y", 32'(s_y), 3);
    run(1);
    chk("v490_y", 32'(v_y), 490);
    chk("v490_vsync", 32'(v_vs), 0);
    run(15);
    chk("v491_vsync", 32'(v_vs), 0);
    run(1);
    chk("v492_vsync", 32'(v_vs), 1);
    run(263);
    chk("v524_y", 32'(v_y), 524);
    chk("v_frame_end", 32'(v_fe), 1);
    chk("s_count4199_frame_end", 32'(s_fe), 0);
    chk("s_count4199_line_end", 32'(s_le), 1);
    run(1);
    chk("v_wrap_x", 32'(v_x), 0);
    chk("v_wrap_y", 32'(v_y), 0);
    chk("v_wrap_frame_end", 32'(v_fe), 0);
    chk("s_count4200_y", 32'(s_y), 3);

    // tiny raster: sync decode and wrap with no overflow
    clear();
    run(33);
    chk("s33_x", 32'(s_x), 1);
    chk("s33_y", 32'(s_y), 4);
    chk("s33_vsync", 32'(s_vs), 0);
    chk("s33_hsync", 32'(s_hs), 1);
    chk("s33_active", 32'(s_act), 0);
    run(7);
    chk("s40_vsync", 32'(s_vs), 1);
    run(7);
    chk("s47_x", 32'(s_x), 7);
    chk("s47_y", 32'(s_y), 5);
    chk("s47_frame_end", 32'(s_fe), 1);
    run(1);
    chk("s48_x", 32'(s_x), 0);
    chk("s48_y", 32'(s_y), 0);
    chk("s48_active", 32'(s_act), 1);
    chk("s48_frame_end", 32'(s_fe), 0);
    run(47);
    chk("s95_frame_end", 32'(s_fe), 1);
    @(negedge clk) i_sclr = 1'b1;
    #1;
    chk("s_sclr_frame_end", 32'(s_fe), 0);
    chk("s_sclr_line_end", 32'(s_le), 0);
    @(negedge clk) begin i_sclr = 1'b0; i_px_clk = 1'b0; end
    #1;
    chk("s_sclr_x", 32'(s_x), 0);
    chk("s_sclr_y", 32'(s_y), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
